// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: load funct3 codes,
// FSM states and the hard-wired zero register.
package writeback_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    S_IDLE,
    S_WAIT_LOAD
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_align.sv
// Load data extract/extend plus misalignment and undefined-type check.
// Purely combinational.
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        fault_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o  = '0;
    fault_o = 1'b0;
    unique case (funct3_i)
      F3_LB: begin
        data_o = {{24{byte_v[7]}}, byte_v};
      end
      F3_LBU: begin
        data_o = {24'd0, byte_v};
      end
      F3_LH: begin
        data_o  = {{16{half_v[15]}}, half_v};
        fault_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o  = {16'd0, half_v};
        fault_o = addr_lo_i[0];
      end
      F3_LW: begin
        data_o  = rdata_i;
        fault_o = (addr_lo_i != 2'b00);
      end
      default: begin
        fault_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: register-file write port, load completion,
// retire counter. Define WB_BYPASS_EN to add the bypass/pending port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_alu,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             wrEn,
  output logic [4:0]       Rdst_in,
  output logic [31:0]      RWrdata,
  output logic             load_err,
`ifdef WB_BYPASS_EN
  output logic             bp_valid,
  output logic [4:0]       bp_rd,
  output logic [31:0]      bp_data,
  output logic             bp_pending,
  output logic [4:0]       bp_pending_rd,
`endif
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(LOAD_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  wb_state_e        state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       alo_q, alo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_n_q, wr_n_d;
  logic [4:0]       rdst_q, rdst_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic        idle;
  logic [2:0]  al_f3;
  logic [1:0]  al_alo;
  logic [31:0] al_data;
  logic        al_fault;

  assign idle = (state_q == S_IDLE);

  // In IDLE the aligner checks the incoming load; while waiting it
  // extracts data using the latched type and offset.
  assign al_f3  = idle ? in_funct3  : f3_q;
  assign al_alo = idle ? in_addr_lo : alo_q;

  load_align u_align (
    .funct3_i  (al_f3),
    .addr_lo_i (al_alo),
    .rdata_i   (mem_rdata),
    .data_o    (al_data),
    .fault_o   (al_fault)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    cnt_d   = cnt_q;
    wr_n_d  = 1'b1;
    rdst_d  = rdst_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_is_load) begin
            ret_d = ret_q + ONE;
            if (in_rd != REG_X0) begin
              wr_n_d  = 1'b0;
              rdst_d  = in_rd;
              wdata_d = in_alu;
            end
          end else if (al_fault) begin
            err_d = 1'b1;
            ret_d = ret_q + ONE;
          end else begin
            rd_d    = in_rd;
            f3_d    = in_funct3;
            alo_d   = in_addr_lo;
            cnt_d   = '0;
            state_d = S_WAIT_LOAD;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          ret_d   = ret_q + ONE;
          if (rd_q != REG_X0) begin
            wr_n_d  = 1'b0;
            rdst_d  = rd_q;
            wdata_d = al_data;
          end
        end else if (cnt_q == TO_VAL) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          ret_d   = ret_q + ONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      cnt_q   <= '0;
      wr_n_q  <= 1'b1;
      rdst_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      cnt_q   <= cnt_d;
      wr_n_q  <= wr_n_d;
      rdst_q  <= rdst_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  assign in_ready   = idle;
  assign wrEn       = wr_n_q;
  assign Rdst_in    = rdst_q;
  assign RWrdata    = wdata_q;
  assign load_err   = err_q;
  assign retire_cnt = ret_q;

`ifdef WB_BYPASS_EN
  assign bp_valid      = !wr_n_q;
  assign bp_rd         = rdst_q;
  assign bp_data       = wdata_q;
  assign bp_pending    = (state_q == S_WAIT_LOAD);
  assign bp_pending_rd = rd_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes are queued by
// the stimulus and popped by a monitor whenever wrEn pulses low.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wrEn;
  logic [4:0]  Rdst_in;
  logic [31:0] RWrdata;
  logic        load_err;
  logic [31:0] retire_cnt;
`ifdef WB_BYPASS_EN
  logic        bp_valid;
  logic [4:0]  bp_rd;
  logic [31:0] bp_data;
  logic        bp_pending;
  logic [4:0]  bp_pending_rd;
`endif

  writeback_stage #(.LOAD_TIMEOUT(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_alu     (in_alu),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wrEn       (wrEn),
    .Rdst_in    (Rdst_in),
    .RWrdata    (RWrdata),
    .load_err   (load_err),
`ifdef WB_BYPASS_EN
    .bp_valid      (bp_valid),
    .bp_rd         (bp_rd),
    .bp_data       (bp_data),
    .bp_pending    (bp_pending),
    .bp_pending_rd (bp_pending_rd),
`endif
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (wrEn !== 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd %0d data %h, none expected",
                 Rdst_in, RWrdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write_rd", {27'd0, Rdst_in}, {27'd0, e.rd});
        chk("write_data", RWrdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic op_alu(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    in_valid = 1'b1;
    in_is_load = 1'b0;
    in_rd = rd;
    in_alu = d;
    if (rd != 5'd0) begin
      e.rd = rd;
      e.d = d;
      q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic op_load(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] alo);
    in_valid = 1'b1;
    in_is_load = 1'b1;
    in_rd = rd;
    in_funct3 = f3;
    in_addr_lo = alo;
    tick();
    in_valid = 1'b0;
    in_is_load = 1'b0;
  endtask

  task automatic give_data(input logic [4:0] rd, input logic [31:0] raw,
                           input logic [31:0] exp);
    exp_t e;
    mem_rvalid = 1'b1;
    mem_rdata = raw;
    e.rd = rd;
    e.d = exp;
    q.push_back(e);
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wrEn", {31'd0, wrEn}, 32'd1);
    chk("rst_Rdst", {27'd0, Rdst_in}, 32'd0);
    chk("rst_RWrdata", RWrdata, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_rd = '0;
    in_alu = '0;
    in_is_load = 1'b0;
    in_funct3 = '0;
    in_addr_lo = '0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    do_reset();
    chk_reset_vals();

    // Back-to-back ALU writes
    op_alu(5'd1, 32'hA);
    op_alu(5'd2, 32'hB);
    op_alu(5'd3, 32'hC);
    tick();
    chk("retire_after_alu", retire_cnt, 32'd3);

    // mem_rvalid while idle must be ignored
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("idle_rvalid_retire", retire_cnt, 32'd3);

    // LB at offset 2, data in the third cycle after acceptance
    op_load(5'd5, 3'b000, 2'd2);
    chk("lb_ready_c1", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("lb_ready_c3", {31'd0, in_ready}, 32'd0);
    give_data(5'd5, 32'h0080_0000, 32'hFFFF_FF80);
    chk("lb_ready_after", {31'd0, in_ready}, 32'd1);
    chk("lb_retire", retire_cnt, 32'd4);

    op_load(5'd6, 3'b101, 2'd2);
    give_data(5'd6, 32'h8001_0000, 32'h0000_8001);
    op_load(5'd12, 3'b100, 2'd3);
    give_data(5'd12, 32'h9A00_0000, 32'h0000_009A);
    op_load(5'd13, 3'b001, 2'd0);
    give_data(5'd13, 32'h0000_F234, 32'hFFFF_F234);
    op_load(5'd14, 3'b010, 2'd0);
    give_data(5'd14, 32'hCAFE_0123, 32'hCAFE_0123);
    chk("no_err_yet", {31'd0, load_err}, 32'd0);
    chk("retire_loads", retire_cnt, 32'd8);

    // Misaligned LH faults on acceptance
    op_load(5'd7, 3'b001, 2'd1);
    chk("lh_mis_err", {31'd0, load_err}, 32'd1);
    chk("lh_mis_ready", {31'd0, in_ready}, 32'd1);
    chk("lh_mis_retire", retire_cnt, 32'd9);

    // Undefined funct3 also faults and retires
    op_load(5'd7, 3'b011, 2'd0);
    chk("undef_retire", retire_cnt, 32'd10);

    // Timeout: 16 silent cycles then abort on the next edge
    do_reset();
    op_load(5'd8, 3'b010, 2'd0);
    repeat (16) tick();
    chk("to_ready_c17", {31'd0, in_ready}, 32'd0);
    chk("to_err_c17", {31'd0, load_err}, 32'd0);
    tick();
    chk("to_ready_after", {31'd0, in_ready}, 32'd1);
    chk("to_err_after", {31'd0, load_err}, 32'd1);
    chk("to_retire", retire_cnt, 32'd1);
    op_alu(5'd9, 32'h99);
    tick();
    chk("to_then_alu_retire", retire_cnt, 32'd2);

    // Data on the expiry cycle wins
    do_reset();
    op_load(5'd10, 3'b010, 2'd0);
    repeat (16) tick();
    give_data(5'd10, 32'h1234_5678, 32'h1234_5678);
    chk("exp_err", {31'd0, load_err}, 32'd0);
    chk("exp_ready", {31'd0, in_ready}, 32'd1);
    chk("exp_retire", retire_cnt, 32'd1);

    // x0 destination: no write, still retires
    op_alu(5'd0, 32'hDEAD);
    chk("x0_wrEn", {31'd0, wrEn}, 32'd1);
    chk("x0_retire", retire_cnt, 32'd2);
    op_load(5'd0, 3'b010, 2'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("x0_load_retire", retire_cnt, 32'd3);

    // Reset in WAIT_LOAD abandons the load, even with rvalid present
    op_load(5'd11, 3'b010, 2'd0);
    tick();
    rst_n = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    chk_reset_vals();
    repeat (3) tick();
    chk("final_wrEn", {31'd0, wrEn}, 32'd1);

    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
